quickq_cmd_driver: RTL and testbench

//  Host-side initiator for the QuickQ priority-queue core. Accepts enqueue/dequeue commands on a

---
 rtl/quickq_pkg.sv | 23 ++
 rtl/quickq_cmd_driver_if.sv | 23 ++
 rtl/quickq_timeout_ctr.sv | 26 ++
 rtl/quickq_cmd_driver.sv | 150 +++++++++++++++
 tb/tb_quickq_cmd_driver.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quickq_pkg.sv
// rtl/quickq_pkg.sv - shared op, status and state types for the QuickQ command driver
package quickq_pkg;

   typedef enum logic {
      OP_ENQ = 1'b0,
      OP_DEQ = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_FULL    = 2'b01,
      ST_EMPTY   = 2'b10,
      ST_TIMEOUT = 2'b11
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } drv_state_e;

endpackage

// File: rtl/quickq_cmd_driver_if.sv
// rtl/quickq_cmd_driver_if.sv - host command/response handshake bundle for the QuickQ driver
interface quickq_cmd_driver_if #(
   parameter int W = 32
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_op;
   logic [W-1:0] cmd_data;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic [1:0]   rsp_status;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_status
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_status
   );
endinterface

// File: rtl/quickq_timeout_ctr.sv
// rtl/quickq_timeout_ctr.sv - in-flight cycle counter; expired once the count reaches TIMEOUT-1
module quickq_timeout_ctr #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   assign expired = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/quickq_cmd_driver.sv
// rtl/quickq_cmd_driver.sv - single-outstanding QuickQ core initiator; QUICKQ_DRV_STATS_EN adds response counters
module quickq_cmd_driver
   import quickq_pkg::*;
#(
   parameter int W       = 32,
   parameter int TIMEOUT = 64
`ifdef QUICKQ_DRV_STATS_EN
   ,
   parameter int CNT_W   = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   quickq_cmd_driver_if.slave   host,
   output logic                 q_enq,
   output logic                 q_deq,
   output logic [W-1:0]         q_data,
   input  logic                 q_done,
   input  logic                 q_full,
   input  logic                 q_empty,
   input  logic [W-1:0]         q_min
`ifdef QUICKQ_DRV_STATS_EN
   ,
   output logic [CNT_W-1:0]     stat_enq,
   output logic [CNT_W-1:0]     stat_deq,
   output logic [CNT_W-1:0]     stat_err
`endif
);

   drv_state_e   state;
   op_e          op_q;
   op_e          cmd_op;
   status_e      status_q;
   logic         cmd_ready_q;
   logic         rsp_valid_q;
   logic [W-1:0] rsp_data_q;
   logic         accept;
   logic         rsp_hs;
   logic         in_flight;
   logic         tmo_expired;

   assign cmd_op    = op_e'(host.cmd_op);
   assign accept    = cmd_ready_q & host.cmd_valid;
   assign rsp_hs    = rsp_valid_q & host.rsp_ready;
   assign in_flight = (state == S_ISSUE) || (state == S_WAIT);

   assign host.cmd_ready  = cmd_ready_q;
   assign host.rsp_valid  = rsp_valid_q;
   assign host.rsp_data   = rsp_data_q;
   assign host.rsp_status = status_q;

   // Held at zero outside ISSUE/WAIT, so the count reads 0 in the ISSUE cycle.
   quickq_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (!in_flight),
      .enable  (in_flight),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         op_q        <= OP_ENQ;
         status_q    <= ST_OK;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         q_enq       <= 1'b0;
         q_deq       <= 1'b0;
         q_data      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  op_q        <= cmd_op;
                  if (cmd_op == OP_ENQ && q_full) begin
                     rsp_valid_q <= 1'b1;
                     status_q    <= ST_FULL;
                     rsp_data_q  <= '0;
                     state       <= S_RESP;
                  end else if (cmd_op == OP_DEQ && q_empty) begin
                     rsp_valid_q <= 1'b1;
                     status_q    <= ST_EMPTY;
                     rsp_data_q  <= '0;
                     state       <= S_RESP;
                  end else begin
                     // DEQ carries no payload, so the core sees zero rather than stale host data.
                     q_enq  <= (cmd_op == OP_ENQ);
                     q_deq  <= (cmd_op == OP_DEQ);
                     q_data <= (cmd_op == OP_ENQ) ? host.cmd_data : '0;
                     state  <= S_ISSUE;
                  end
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            S_ISSUE, S_WAIT: begin
               q_enq <= 1'b0;
               q_deq <= 1'b0;
               if (q_done) begin
                  rsp_valid_q <= 1'b1;
                  status_q    <= ST_OK;
                  rsp_data_q  <= (op_q == OP_DEQ) ? q_min : '0;
                  q_data      <= '0;
                  state       <= S_RESP;
               end else if (state == S_WAIT && tmo_expired) begin
                  rsp_valid_q <= 1'b1;
                  status_q    <= ST_TIMEOUT;
                  rsp_data_q  <= '0;
                  q_data      <= '0;
                  state       <= S_RESP;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_RESP: begin
               if (rsp_hs) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef QUICKQ_DRV_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_enq <= '0;
         stat_deq <= '0;
         stat_err <= '0;
      end else if (rsp_hs) begin
         if (status_q != ST_OK) begin
            if (stat_err != '1) stat_err <= stat_err + CNT_W'(1);
         end else if (op_q == OP_ENQ) begin
            if (stat_enq != '1) stat_enq <= stat_enq + CNT_W'(1);
         end else begin
            if (stat_deq != '1) stat_deq <= stat_deq + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_quickq_cmd_driver.sv
// tb/tb_quickq_cmd_driver.sv - scoreboard bench for quickq_cmd_driver (QUICKQ_DRV_STATS_EN optional)
module tb_quickq_cmd_driver;
   import quickq_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  status;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        q_enq, q_deq;
   logic [31:0] q_data;
   logic        q_done;
   logic        core_done, stray_done;
   logic        q_full, q_empty;
   logic [31:0] q_min;
`ifdef QUICKQ_DRV_STATS_EN
   logic [15:0] stat_enq, stat_deq, stat_err;
`endif

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          n_enq = 0, n_deq = 0, both_cnt = 0;
   logic [31:0] last_q_data = '0;
   int          done_delay = -1;
   logic [31:0] min_val = '0;
   exp_t        sb[$];

   quickq_cmd_driver_if #(.W(32)) hif ();

   assign q_done = core_done | stray_done;

   quickq_cmd_driver #(
      .W       (32),
      .TIMEOUT (64)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .host    (hif),
      .q_enq   (q_enq),
      .q_deq   (q_deq),
      .q_data  (q_data),
      .q_done  (q_done),
      .q_full  (q_full),
      .q_empty (q_empty),
      .q_min   (q_min)
`ifdef QUICKQ_DRV_STATS_EN
      ,
      .stat_enq (stat_enq),
      .stat_deq (stat_deq),
      .stat_err (stat_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Pulse observer on the core side.
   always @(negedge clk) begin
      if (q_enq) begin
         n_enq++;
         last_q_data = q_data;
      end
      if (q_deq) n_deq++;
      if (q_enq && q_deq) both_cnt++;
   end

   // Core model: answers each pulse with q_done after done_delay cycles (-1 = never).
   initial begin
      core_done = 1'b0;
      q_min     = '0;
      forever begin
         @(negedge clk);
         if ((q_enq || q_deq) && done_delay >= 0) begin
            q_min = min_val;
            if (done_delay == 0) begin
               core_done = 1'b1;
            end else begin
               repeat (done_delay) @(posedge clk);
               #1 core_done = 1'b1;
            end
            @(posedge clk);
            #1 core_done = 1'b0;
         end
      end
   end

   // Response monitor: pops the scoreboard on each handshake.
   initial begin
      bit   seen;
      int   first_cyc;
      exp_t e;
      seen = 0;
      first_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            seen = 0;
         end else if (hif.rsp_valid) begin
            if (!seen) begin
               seen = 1;
               first_cyc = cyc;
            end
            if (hif.rsp_ready) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_rsp: got data %0h status %0d, required no response",
                           hif.rsp_data, hif.rsp_status);
               end else begin
                  e = sb.pop_front();
                  check("rsp_data", 64'(hif.rsp_data), 64'(e.data));
                  check("rsp_status", 64'(hif.rsp_status), 64'(e.status));
                  check("rsp_latency", 64'(first_cyc - acc_cyc), 64'(e.lat));
               end
               seen = 0;
            end
         end
      end
   end

   task automatic send(input logic op, input logic [31:0] d, output bit ok);
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b1;
      hif.cmd_op    = op;
      hif.cmd_data  = d;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (hif.cmd_ready) begin
            ok = 1;
            acc_cyc = cyc;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL cmd_accept: cmd_ready stayed 0 for 200 cycles, required 1");
      end
      @(posedge clk);
      #1 hif.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL rsp_wait: %0d responses pending after 300 cycles, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic op, input logic [31:0] d, input int dly,
                         input logic [31:0] mn, input logic [31:0] ed, input logic [1:0] es,
                         input int el, input int ee, input int edq);
      int e0, d0;
      bit ok;
      e0 = n_enq;
      d0 = n_deq;
      done_delay = dly;
      min_val = mn;
      sb.push_back('{ed, es, el});
      send(op, d, ok);
      wait_rsp();
      check("q_enq_pulses", 64'(n_enq - e0), 64'(ee));
      check("q_deq_pulses", 64'(n_deq - d0), 64'(edq));
      if (ee == 1) check("q_data", 64'(last_q_data), 64'(d));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(hif.cmd_ready), 64'(0));
      check({tag, "_rsp_valid"}, 64'(hif.rsp_valid), 64'(0));
      check({tag, "_q_enq"}, 64'(q_enq), 64'(0));
      check({tag, "_q_deq"}, 64'(q_deq), 64'(0));
      check({tag, "_q_data"}, 64'(q_data), 64'(0));
      check({tag, "_rsp_data"}, 64'(hif.rsp_data), 64'(0));
      check({tag, "_rsp_status"}, 64'(hif.rsp_status), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int e0, d0;
      rst = 1'b0;
      hif.cmd_valid = 1'b0;
      hif.cmd_op    = 1'b0;
      hif.cmd_data  = '0;
      hif.rsp_ready = 1'b1;
      q_full = 1'b0;
      q_empty = 1'b0;
      stray_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b1;

      // Normal ENQ / DEQ, including q_done in the ISSUE cycle.
      do_cmd(OP_ENQ, 32'h0000_0010, 3, 32'h0, 32'h0, ST_OK, 5, 1, 0);
      do_cmd(OP_DEQ, 32'h0, 2, 32'h0000_0005, 32'h5, ST_OK, 4, 0, 1);
      do_cmd(OP_ENQ, 32'h0000_0077, 0, 32'h0, 32'h0, ST_OK, 2, 1, 0);

      // Reject paths; full does not block a DEQ.
      q_empty = 1'b1;
      do_cmd(OP_DEQ, 32'h0, 2, 32'h9, 32'h0, ST_EMPTY, 1, 0, 0);
      q_empty = 1'b0;
      q_full = 1'b1;
      do_cmd(OP_ENQ, 32'h33, 2, 32'h0, 32'h0, ST_FULL, 1, 0, 0);
      do_cmd(OP_DEQ, 32'h0, 1, 32'h0000_000A, 32'hA, ST_OK, 3, 0, 1);
      q_full = 1'b0;

      // Timeout: decided in cycle 64 after accept, response visible in cycle 65.
      do_cmd(OP_ENQ, 32'h44, -1, 32'h0, 32'h0, ST_TIMEOUT, 65, 1, 0);
      stray_done = 1'b1;
      @(posedge clk);
      #1 stray_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_done_idle_rsp_valid", 64'(hif.rsp_valid), 64'(0));
      end

      // Back-pressure: response held, second command refused.
      hif.rsp_ready = 1'b0;
      e0 = n_enq;
      d0 = n_deq;
      done_delay = 1;
      min_val = 32'h0000_005A;
      sb.push_back('{32'h5A, ST_OK, 3});
      send(OP_DEQ, 32'h0, ok);
      for (int i = 0; i < 20 && !hif.rsp_valid; i++) @(negedge clk);
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b1;
      hif.cmd_op    = OP_ENQ;
      hif.cmd_data  = 32'h66;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_rsp_valid", 64'(hif.rsp_valid), 64'(1));
         check("hold_rsp_data", 64'(hif.rsp_data), 64'(32'h5A));
         check("hold_rsp_status", 64'(hif.rsp_status), 64'(ST_OK));
         check("hold_cmd_ready", 64'(hif.cmd_ready), 64'(0));
         if (i == 3) stray_done = 1'b1;
         if (i == 4) stray_done = 1'b0;
      end
      @(posedge clk);
      #1;
      hif.cmd_valid = 1'b0;
      hif.rsp_ready = 1'b1;
      check("hold_q_enq_pulses", 64'(n_enq - e0), 64'(0));
      check("hold_q_deq_pulses", 64'(n_deq - d0), 64'(1));
      wait_rsp();

      // Reset while waiting on the core.
      do_cmd(OP_DEQ, 32'h0, 1, 32'h0000_0099, 32'h99, ST_OK, 3, 0, 1);
      done_delay = -1;
      send(OP_ENQ, 32'h0000_ABCD, ok);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk);
      #1 rst = 1'b1;
`ifdef QUICKQ_DRV_STATS_EN
      check("stat_enq_reset", 64'(stat_enq), 64'(0));
      check("stat_deq_reset", 64'(stat_deq), 64'(0));
      check("stat_err_reset", 64'(stat_err), 64'(0));
`endif

      for (int i = 0; i < 3; i++) begin
         do_cmd(OP_ENQ, 32'h100 + 32'(i), 1, 32'h0, 32'h0, ST_OK, 3, 1, 0);
      end
      q_empty = 1'b1;
      do_cmd(OP_DEQ, 32'h0, 1, 32'h0, 32'h0, ST_EMPTY, 1, 0, 0);
      q_empty = 1'b0;
      @(negedge clk);
`ifdef QUICKQ_DRV_STATS_EN
      check("stat_enq", 64'(stat_enq), 64'(3));
      check("stat_deq", 64'(stat_deq), 64'(0));
      check("stat_err", 64'(stat_err), 64'(1));
`endif
      check("enq_deq_overlap", 64'(both_cnt), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
